seq_transport_ctrl: RTL and testbench

Transport controller for the 8-step drum sequencer: turns debounced play/pause, stop and manual-step button pulses plus a tempo period into the one-cycle `go_left`, `go_right` and `srst` pulses that drive the one-hot step register. It also tracks the current step index and emits a per-step trigger for the voice/sample logic. It sits between the button debouncers and the sequencer. It is the only block driving the sequencer's step controls.

---
 rtl/seq_transport_if.sv | 29 ++
 rtl/seq_transport_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_transport_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_transport_if.sv
// Transport bundle between the button/tempo side and the sequencer step controller.
// master drives buttons, direction and tempo; slave is the controller producing step pulses.
interface seq_transport_if #(
  parameter int unsigned PERIOD_W = 24
);
  logic                play_btn;
  logic                stop_btn;
  logic                step_btn;
  logic                dir;
  logic [PERIOD_W-1:0] period;
  logic                go_right;
  logic                go_left;
  logic                srst;
  logic                step_tick;
  logic                bar_tick;
  logic [2:0]          step_idx;
  logic                playing;
  logic                paused;

  modport master (
    output play_btn, stop_btn, step_btn, dir, period,
    input  go_right, go_left, srst, step_tick, bar_tick, step_idx, playing, paused
  );

  modport slave (
    input  play_btn, stop_btn, step_btn, dir, period,
    output go_right, go_left, srst, step_tick, bar_tick, step_idx, playing, paused
  );
endinterface

// File: rtl/seq_transport_ctrl.sv
// Play/pause/stop/step transport for the 8-step sequencer: tempo counter, one-cycle go/srst
// pulses, and a step index that mirrors the sequencer's one-hot position.
module seq_transport_ctrl #(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned MIN_PERIOD = 4
) (
  input logic            clk,
  input logic            rst,
  seq_transport_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPlay, StPause} state_e;

  state_e              state_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] reload;
  logic                go_left_q;
  logic                go_right_q;
  logic                srst_q;
  logic                entry_q;
  logic                step_tick_q;
  logic                bar_tick_q;
  logic                playing_q;
  logic                paused_q;
  logic [2:0]          step_idx_q;
  logic [2:0]          idx_next;
  logic                tick_next;

  // Reload value is eff_period-1 with eff_period clamped up to MIN_PERIOD.
  always_comb begin
    reload = bus.period - PERIOD_W'(1);
    if (bus.period < PERIOD_W'(MIN_PERIOD)) begin
      reload = PERIOD_W'(MIN_PERIOD - 1);
    end
  end

  // Index follows whatever pulse the sequencer consumes at the coming edge.
  always_comb begin
    idx_next = step_idx_q;
    if (srst_q) begin
      idx_next = 3'd0;
    end else if (go_right_q) begin
      idx_next = step_idx_q + 3'd1;
    end else if (go_left_q) begin
      idx_next = step_idx_q - 3'd1;
    end
    tick_next = go_right_q | go_left_q | entry_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      go_left_q   <= 1'b0;
      go_right_q  <= 1'b0;
      srst_q      <= 1'b0;
      entry_q     <= 1'b0;
      step_tick_q <= 1'b0;
      bar_tick_q  <= 1'b0;
      playing_q   <= 1'b0;
      paused_q    <= 1'b0;
      step_idx_q  <= 3'd0;
    end else begin
      go_left_q   <= 1'b0;
      go_right_q  <= 1'b0;
      srst_q      <= 1'b0;
      entry_q     <= 1'b0;
      step_idx_q  <= idx_next;
      step_tick_q <= tick_next;
      bar_tick_q  <= tick_next && (idx_next == 3'd0);

      if (bus.stop_btn) begin
        state_q   <= StIdle;
        playing_q <= 1'b0;
        paused_q  <= 1'b0;
        cnt_q     <= '0;
        srst_q    <= 1'b1;
      end else if (bus.play_btn) begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StPlay;
            playing_q <= 1'b1;
            paused_q  <= 1'b0;
            cnt_q     <= reload;
            entry_q   <= 1'b1;
          end
          StPlay: begin
            // Pause wins over an expiry in the same cycle; counter is frozen as-is.
            state_q   <= StPause;
            playing_q <= 1'b0;
            paused_q  <= 1'b1;
          end
          StPause: begin
            state_q   <= StPlay;
            playing_q <= 1'b1;
            paused_q  <= 1'b0;
          end
          default: begin
            state_q   <= StIdle;
            playing_q <= 1'b0;
            paused_q  <= 1'b0;
          end
        endcase
      end else if (bus.step_btn && (state_q != StPlay)) begin
        go_left_q  <= bus.dir;
        go_right_q <= ~bus.dir;
      end else if (state_q == StPlay) begin
        if (cnt_q == '0) begin
          go_left_q  <= bus.dir;
          go_right_q <= ~bus.dir;
          cnt_q      <= reload;
        end else begin
          cnt_q <= cnt_q - PERIOD_W'(1);
        end
      end
    end
  end

  assign bus.go_right  = go_right_q;
  assign bus.go_left   = go_left_q;
  assign bus.srst      = srst_q;
  assign bus.step_tick = step_tick_q;
  assign bus.bar_tick  = bar_tick_q;
  assign bus.step_idx  = step_idx_q;
  assign bus.playing   = playing_q;
  assign bus.paused    = paused_q;

endmodule

// File: tb/tb_seq_transport_ctrl.sv
// Bench for seq_transport_ctrl: a timeline model (scheduled pulses plus a one-hot sequencer)
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_seq_transport_ctrl;
  localparam int unsigned PW    = 24;
  localparam int          Depth = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_transport_if #(.PERIOD_W(PW)) bus ();

  seq_transport_ctrl #(.PERIOD_W(PW), .MIN_PERIOD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: per-cycle expected pulses (bit0 right, bit1 left, bit2 srst, bit3 tick).
  bit [3:0]   exp_ev [Depth];
  int         cyc       = 0;
  int         mode      = 0;  // 0 idle, 1 play, 2 pause
  int         next_ev   = 0;
  int         remaining = 0;
  int         k         = 0;
  logic [7:0] seq       = 8'h80;

  function automatic int eff(input logic [PW-1:0] p);
    return (p < 4) ? 4 : int'(p);
  endfunction

  function automatic int idx_of(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[7-i]) return i;
    return -1;
  endfunction

  task automatic mark(input int at, input int kind);
    if (at < Depth) exp_ev[at][kind] = 1'b1;
  endtask

  task automatic go_event(input int at);
    mark(at + 1, bus.dir ? 1 : 0);
    mark(at + 2, 3);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mode = 0;
        seq  = 8'h80;
        foreach (exp_ev[i]) exp_ev[i] = 4'b0;
      end else begin
        k = cyc;
        if (bus.stop_btn) begin
          mode = 0;
          mark(k + 1, 2);
        end else if (bus.play_btn) begin
          if (mode == 0) begin
            mode    = 1;
            next_ev = k + eff(bus.period);
            mark(k + 2, 3);
          end else if (mode == 1) begin
            mode      = 2;
            remaining = next_ev - k;
          end else begin
            mode    = 1;
            next_ev = k + 1 + remaining;
          end
        end else if (bus.step_btn && mode != 1) begin
          go_event(k);
        end else if (mode == 1 && k == next_ev) begin
          go_event(k);
          next_ev = k + eff(bus.period);
        end
        // Sequencer consumes the pulse present during cycle k.
        if (k < Depth) begin
          if (exp_ev[k][0]) seq = {seq[0], seq[7:1]};
          else if (exp_ev[k][1]) seq = {seq[6:0], seq[7]};
          else if (exp_ev[k][2]) seq = 8'h80;
        end
        cyc = cyc + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cyc < Depth) begin
        chk("go_right", bus.go_right, exp_ev[cyc][0]);
        chk("go_left", bus.go_left, exp_ev[cyc][1]);
        chk("srst", bus.srst, exp_ev[cyc][2]);
        chk("step_tick", bus.step_tick, exp_ev[cyc][3]);
        chk("bar_tick", bus.bar_tick, int'(exp_ev[cyc][3] && idx_of(seq) == 0));
        chk("step_idx", bus.step_idx, idx_of(seq));
        chk("playing", bus.playing, int'(mode == 1));
        chk("paused", bus.paused, int'(mode == 2));
        chk("pulse_excl", int'(bus.go_right) + int'(bus.go_left) + int'(bus.srst) <= 1, 1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) next_cycle();
  endtask

  // which: bit0 play, bit1 stop, bit2 step
  task automatic press(input int which);
    bus.play_btn = which[0];
    bus.stop_btn = which[1];
    bus.step_btn = which[2];
    next_cycle();
    bus.play_btn = 1'b0;
    bus.stop_btn = 1'b0;
    bus.step_btn = 1'b0;
  endtask

  task automatic rewind();
    press(2);
    adv(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.play_btn = 1'b0;
    bus.stop_btn = 1'b0;
    bus.step_btn = 1'b0;
    bus.dir      = 1'b0;
    bus.period   = 24'd10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();
    chk("rst_playing", bus.playing, 0);
    chk("rst_idx", bus.step_idx, 0);
    chk("rst_tick", bus.step_tick, 0);

    // Play with period 10 from IDLE at cycle N.
    press(1);                                  // N+1
    chk("start_playing", bus.playing, 1);
    adv(1);                                    // N+2
    chk("entry_tick", bus.step_tick, 1);
    chk("entry_bar", bus.bar_tick, 1);
    chk("entry_idx", bus.step_idx, 0);
    adv(9);                                    // N+11
    chk("first_go", bus.go_right, 1);
    adv(1);                                    // N+12
    chk("tick1", bus.step_tick, 1);
    chk("tick1_idx", bus.step_idx, 1);
    adv(10);                                   // N+22
    chk("tick2_idx", bus.step_idx, 2);
    adv(60);                                   // N+82: eighth step wraps to 0
    chk("wrap_bar", bus.bar_tick, 1);
    chk("wrap_idx", bus.step_idx, 0);

    press(2);
    chk("stop_srst", bus.srst, 1);
    chk("stop_playing", bus.playing, 0);
    adv(1);
    chk("stop_idx", bus.step_idx, 0);
    chk("stop_no_tick", bus.step_tick, 0);

    // Manual left step from IDLE.
    bus.dir = 1'b1;
    press(4);
    chk("man_left", bus.go_left, 1);
    adv(1);
    chk("man_idx", bus.step_idx, 7);
    chk("man_tick", bus.step_tick, 1);
    chk("man_bar", bus.bar_tick, 0);
    rewind();

    // Step button ignored while playing.
    bus.dir = 1'b0;
    press(1);
    adv(4);
    press(4);
    chk("play_step_r", bus.go_right, 0);
    chk("play_step_l", bus.go_left, 0);
    adv(20);
    rewind();

    // Period below the floor is clamped to 4.
    bus.period = 24'd2;
    press(1);                                  // N+1
    adv(3);                                    // N+4
    chk("clamp_early", bus.go_right, 0);
    adv(1);                                    // N+5
    chk("clamp_go", bus.go_right, 1);
    adv(4);                                    // N+9
    chk("clamp_go2", bus.go_right, 1);
    rewind();

    // Period change mid-step applies from the next reload.
    bus.period = 24'd10;
    press(1);                                  // N+1
    adv(2);                                    // N+3
    bus.period = 24'd20;
    adv(8);                                    // N+11
    chk("per_old", bus.go_right, 1);
    adv(10);                                   // N+21
    chk("per_not10", bus.go_right, 0);
    adv(10);                                   // N+31
    chk("per_new", bus.go_right, 1);
    rewind();

    // Pause at step 3 with 5 cycles left, resume 50 cycles later.
    bus.period = 24'd10;
    press(1);                                  // N+1
    adv(34);                                   // N+35
    press(1);                                  // N+36
    chk("pause_flag", bus.paused, 1);
    adv(49);                                   // N+85
    press(1);                                  // N+86
    adv(6);                                    // N+92
    chk("resume_go", bus.go_right, 1);
    adv(1);                                    // N+93
    chk("resume_idx", bus.step_idx, 4);
    adv(8);                                    // N+101: counter at 0
    press(1);                                  // N+102
    chk("pause_exp_go", bus.go_right, 0);
    chk("pause_exp_flag", bus.paused, 1);
    adv(5);                                    // N+107
    press(1);                                  // N+108
    adv(1);                                    // N+109
    chk("resume_exp_go", bus.go_right, 1);

    // Play and stop together: stop wins.
    press(3);
    chk("both_srst", bus.srst, 1);
    chk("both_playing", bus.playing, 0);
    chk("both_paused", bus.paused, 0);
    adv(2);

    // Asynchronous reset mid-step.
    press(1);
    adv(15);
    rst = 1'b1;
    #1;
    chk("arst_idx", bus.step_idx, 0);
    chk("arst_playing", bus.playing, 0);
    chk("arst_go", int'(bus.go_right) + int'(bus.go_left) + int'(bus.srst), 0);
    chk("arst_tick", int'(bus.step_tick) + int'(bus.bar_tick), 0);
    adv(2);
    rst = 1'b0;
    adv(3);
    press(1);                                  // N+1
    adv(1);                                    // N+2
    chk("restart_tick", bus.step_tick, 1);
    chk("restart_idx", bus.step_idx, 0);
    adv(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
